muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the single-cycle core.
- Takes both source operands as read from the register file and the decoded funct3 and rd.
- Produces a 32-bit result with a one-cycle write-enable pulse that drives the register file write port (data, address, enable) in place of the normal writeback path.
- Asserts `busy` so control can freeze the PC and suppress the normal writeback while an M-extension instruction is in flight.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_div_core.sv | 47 ++++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: width, funct3 codes,
// FSM states and the fixed results of the divide special cases.
package mdu_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

   // Two's-complement negate when neg is set.
   function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
      return neg ? ((~v) + {{(XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring unsigned divider on operand magnitudes: one quotient bit per
// enabled step, dividend bits shift out of the quotient register as it fills.
module mdu_div_core
   import mdu_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_load,
   input  logic            i_step,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_quo,
   output logic [XLEN-1:0] o_rem
);

   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_dvs;
   logic [XLEN:0]   w_trial;
   logic            w_fits;

   // Shifted partial remainder is one bit wider than XLEN, so the trial keeps a borrow bit.
   assign w_trial = {r_rem, r_quo[XLEN-1]} - {1'b0, r_dvs};
   assign w_fits  = ~w_trial[XLEN];

   // Load operands or perform one restoring step.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_rem <= {XLEN{1'b0}};
         r_quo <= {XLEN{1'b0}};
         r_dvs <= {XLEN{1'b0}};
      end else if (i_load) begin
         r_rem <= {XLEN{1'b0}};
         r_quo <= i_dividend;
         r_dvs <= i_divisor;
      end else if (i_step) begin
         r_rem <= w_fits ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_quo[XLEN-1]};
         r_quo <= {r_quo[XLEN-2:0], w_fits};
      end else begin
         r_rem <= r_rem;
      end
   end

   assign o_quo = r_quo;
   assign o_rem = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Define MDU_FAST_MUL_EN to replace the
// shift-add multiplier with a single-cycle combinational multiply.
module muldiv_unit
   import mdu_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [4:0]      i_rd_in,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_we,
   output logic [4:0]      o_rd_out,
   output logic [XLEN-1:0] o_result
);

   localparam int            CW       = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_f3;
   logic [4:0]        r_rd;
   logic              r_neg_q, r_neg_r, r_bypass;
   logic [CW-1:0]     r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_mcand, r_result;

   logic              w_accept, w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
   logic              w_div_zero, w_div_ovf, w_bypass, w_last;
   logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res, w_bypass_res;
   logic [XLEN:0]     w_sum;
   logic [2*XLEN-1:0] w_acc_step, w_prod;
   logic [XLEN-1:0]   w_mul_res, w_div_res, w_quo, w_rem;

   assign w_accept   = (r_state == S_IDLE) && i_start;
   assign w_is_div   = i_funct3[2];
   assign w_a_signed = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU)
                       || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
   assign w_b_signed = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH)
                       || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
   assign w_sa       = w_a_signed && i_op_a[XLEN-1];
   assign w_sb       = w_b_signed && i_op_b[XLEN-1];
   assign w_mag_a    = cond_neg(w_sa, i_op_a);
   assign w_mag_b    = cond_neg(w_sb, i_op_b);
   assign w_div_zero = (i_op_b == {XLEN{1'b0}});
   assign w_div_ovf  = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM))
                       && (i_op_a == INT_MIN) && (i_op_b == DIV_ZERO_Q);

   // Divide special cases: funct3[1] separates REM/REMU from DIV/DIVU.
   always_comb begin
      w_spec_res = {XLEN{1'b0}};
      if (w_div_zero) begin
         w_spec_res = i_funct3[1] ? i_op_a : DIV_ZERO_Q;
      end else begin
         w_spec_res = i_funct3[1] ? {XLEN{1'b0}} : INT_MIN;
      end
   end

`ifdef MDU_FAST_MUL_EN
   logic signed [XLEN:0]     w_fa, w_fb;
   logic signed [2*XLEN-1:0] w_fprod;
   assign w_fa         = {w_a_signed && i_op_a[XLEN-1], i_op_a};
   assign w_fb         = {w_b_signed && i_op_b[XLEN-1], i_op_b};
   assign w_fprod      = w_fa * w_fb;
   assign w_bypass     = !w_is_div || w_div_zero || w_div_ovf;
   assign w_bypass_res = w_is_div ? w_spec_res
                       : ((i_funct3 == F3_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN]);
`else
   assign w_bypass     = w_is_div && (w_div_zero || w_div_ovf);
   assign w_bypass_res = w_spec_res;
`endif

   assign w_last     = (r_cnt == CNT_LAST);
   assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
   assign w_acc_step = {w_sum, r_acc[XLEN-1:1]};
   assign w_prod     = r_neg_q ? ((~r_acc) + {{(2*XLEN-1){1'b0}}, 1'b1}) : r_acc;
   assign w_mul_res  = (r_f3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
   assign w_div_res  = r_f3[1] ? cond_neg(r_neg_r, w_rem) : cond_neg(r_neg_q, w_quo);

   mdu_div_core u_div (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (w_accept),
      .i_step     ((r_state == S_DIV) && !r_bypass && !w_last),
      .i_dividend (w_mag_a),
      .i_divisor  (w_mag_b),
      .o_quo      (w_quo),
      .o_rem      (w_rem)
   );

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; bypassed ops pass one cycle through DIV so DONE lands on edge 1.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (!i_start)      w_state_nxt = S_IDLE;
            else if (w_bypass) w_state_nxt = S_DIV;
            else if (w_is_div) w_state_nxt = S_DIV;
            else               w_state_nxt = S_MUL;
         end
         S_MUL:   w_state_nxt = w_last ? S_DONE : S_MUL;
         S_DIV:   w_state_nxt = (r_bypass || w_last) ? S_DONE : S_DIV;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      o_busy = 1'b1;
      o_done = 1'b0;
      case (r_state)
         S_IDLE:  o_busy = 1'b0;
         S_DONE:  o_done = 1'b1;
         default: o_busy = 1'b1;
      endcase
   end

   // Operand capture, multiply iteration and result latch.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_f3     <= 3'd0;
         r_rd     <= 5'd0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_bypass <= 1'b0;
         r_cnt    <= {CW{1'b0}};
         r_acc    <= {(2*XLEN){1'b0}};
         r_mcand  <= {XLEN{1'b0}};
         r_result <= {XLEN{1'b0}};
      end else if (w_accept) begin
         r_f3     <= i_funct3;
         r_rd     <= i_rd_in;
         r_neg_q  <= w_sa ^ w_sb;
         r_neg_r  <= w_sa;
         r_bypass <= w_bypass;
         r_cnt    <= {CW{1'b0}};
         r_mcand  <= w_mag_a;
         r_acc    <= {{XLEN{1'b0}}, (w_bypass ? w_bypass_res : w_mag_b)};
      end else if (r_state == S_MUL) begin
         if (w_last) begin
            r_result <= w_mul_res;
         end else begin
            r_acc <= w_acc_step;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
         end
      end else if (r_state == S_DIV) begin
         if (r_bypass)    r_result <= r_acc[XLEN-1:0];
         else if (w_last) r_result <= w_div_res;
         else             r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         r_result <= r_result;
      end
   end

   assign o_we     = o_done;
   assign o_rd_out = r_rd;
   assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed vectors.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [4:0]  rd_in;
   logic [31:0] op_a, op_b;
   logic        busy, done, we;
   logic [4:0]  rd_out;
   logic [31:0] result;

   int n_checks = 0;
   int n_errors = 0;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_EDGE = 1;
`else
   localparam int MUL_EDGE = 33;
`endif

   always #5 clk = ~clk;

   muldiv_unit dut (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_start  (start),
      .i_funct3 (funct3),
      .i_rd_in  (rd_in),
      .i_op_a   (op_a),
      .i_op_b   (op_b),
      .o_busy   (busy),
      .o_done   (done),
      .o_we     (we),
      .o_rd_out (rd_out),
      .o_result (result)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one op and check latency, result, rd, we and busy until done.
   task automatic do_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_edge);
      int  n;
      bit  seen;
      bit  busy_ok;
      @(negedge clk);
      funct3 = f3; rd_in = rd; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0; seen = 0; busy_ok = 1;
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done) seen = 1;
         else if (!busy) busy_ok = 0;
      end
      check_val({tag, "/edge"}, 64'(n), 64'(exp_edge));
      check_val({tag, "/result"}, {32'd0, result}, {32'd0, exp});
      check_val({tag, "/we"}, {63'd0, we}, 64'd1);
      check_val({tag, "/rd"}, {59'd0, rd_out}, {59'd0, rd});
      check_val({tag, "/busy"}, {63'd0, busy_ok}, 64'd1);
      @(negedge clk);
      check_val({tag, "/after"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      int  n;
      bit  seen;
      reset = 1'b0; start = 1'b0; funct3 = 3'd0; rd_in = 5'd0; op_a = 32'd0; op_b = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("reset/outs", {59'd0, busy, done, we, 2'd0}, 64'd0);
      check_val("reset/result", {32'd0, result}, 64'd0);
      check_val("reset/rd", {59'd0, rd_out}, 64'd0);
      reset = 1'b1;

      do_op("mul",    3'd0, 5'd5,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_EDGE);
      do_op("mulh",   3'd1, 5'd6,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_EDGE);
      do_op("mulhu",  3'd3, 5'd7,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_EDGE);
      do_op("mulhsu", 3'd2, 5'd8,  32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, MUL_EDGE);
      do_op("div",    3'd4, 5'd10, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33);
      do_op("rem",    3'd6, 5'd11, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33);
      do_op("divu",   3'd5, 5'd12, 32'd100,        32'd7,         32'd14,        33);
      do_op("remu",   3'd7, 5'd13, 32'd100,        32'd7,         32'd2,         33);

      // Reset during iteration 10 of a divide.
      @(negedge clk);
      funct3 = 3'd5; rd_in = 5'd3; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_val("abort/busy", {63'd0, busy}, 64'd0);
      check_val("abort/result", {32'd0, result}, 64'd0);
      check_val("abort/rd", {59'd0, rd_out}, 64'd0);
      reset = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check_val("abort/nodone", {63'd0, seen}, 64'd0);
      do_op("mul3x4", 3'd0, 5'd9, 32'd3, 32'd4, 32'd12, MUL_EDGE);

      do_op("divu0",  3'd5, 5'd14, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
      do_op("rem0",   3'd6, 5'd15, 32'd5,          32'd0,         32'd5,         1);
      do_op("divovf", 3'd4, 5'd16, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("removf", 3'd6, 5'd17, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

      // Starts while busy (iteration 5) and in the DONE cycle are ignored.
      @(negedge clk);
      funct3 = 3'd5; rd_in = 5'd20; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0; seen = 0;
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 5) begin
            start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd1;
         end else begin
            start = 1'b0;
         end
         if (done) seen = 1;
      end
      check_val("ign/edge", 64'(n), 64'd33);
      check_val("ign/result", {32'd0, result}, 64'd14);
      check_val("ign/rd", {59'd0, rd_out}, 64'd20);
      start = 1'b1; funct3 = 3'd5; op_a = 32'd50; op_b = 32'd5; rd_in = 5'd2;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_val("ign/busy", {62'd0, busy, done}, 64'd0);
      repeat (3) @(negedge clk);
      check_val("ign/hold", {31'd0, busy, result}, 64'd14);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
